fht_input_loader: RTL and testbench

- Upstream stage of fht_control. Accepts a serial stream of time-domain samples over a valid/ready handshake.
- Writes each sample into the four FHT data banks at its bit-reversed position.
- Once a full frame of 4*2^A_BIT samples is stored, issues a one-cycle start pulse to fht_control.
- Then blocks further input until fht_control reports completion via its ready flag.

---
 rtl/fht_pkg.sv | 23 ++
 rtl/fht_bit_reverse.sv | 13 +
 rtl/fht_input_loader.sv | 100 ++++++++++
 tb/tb_fht_input_loader.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fht_pkg.sv
// Shared FHT definitions: loader/control state encoding and frame-size helpers.
package fht_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StFlush,
    StStart,
    StWaitBusy,
    StWaitDone
  } fht_state_e;

  // Points per frame for a given bank address width (four banks).
  function automatic int unsigned fht_frame_len(input int unsigned a_bit);
    return 32'd4 << a_bit;
  endfunction

  // Width of a full point index across all four banks.
  function automatic int unsigned fht_idx_width(input int unsigned a_bit);
    return a_bit + 32'd2;
  endfunction

endpackage

// File: rtl/fht_bit_reverse.sv
// Combinational bit reversal of a W-bit point index.
module fht_bit_reverse #(
  parameter int unsigned W = 4
) (
  input  logic [W-1:0] idx,
  output logic [W-1:0] rev
);

  for (genvar i = 0; i < W; i++) begin : g_rev
    assign rev[i] = idx[W-1-i];
  end

endmodule

// File: rtl/fht_input_loader.sv
// Serial sample loader: writes each accepted sample to the four FHT banks at its
// bit-reversed position, then hands the full frame to fht_control.
module fht_input_loader
  import fht_pkg::*;
#(
  parameter int unsigned A_BIT = 8,
  parameter int unsigned D_BIT = 16
) (
  input  logic               iCLK,
  input  logic               iRESET,
  input  logic               iCLR,
  input  logic [D_BIT-1:0]   iDATA,
  input  logic               iVALID,
  output logic               oREADY,
  output logic [A_BIT-1:0]   oADDR_WR,
  output logic [D_BIT-1:0]   oDATA_WR,
  output logic [3:0]         oWE,
  output logic               oSTART,
  input  logic               iFHT_RDY,
  output logic               oBUSY,
  output logic               oDROP,
  output logic [A_BIT+1:0]   oCNT
);

  localparam int unsigned CW = fht_idx_width(A_BIT);
  localparam logic [CW-1:0] LastIdx = CW'(fht_frame_len(A_BIT) - 1);

  fht_state_e    state_q;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] rev;
  logic          accept;

  fht_bit_reverse #(
    .W (CW)
  ) u_bit_reverse (
    .idx (cnt_q),
    .rev (rev)
  );

  assign oREADY = (state_q == StLoad);
  assign oBUSY  = (state_q == StWaitBusy) || (state_q == StWaitDone);
  assign oCNT   = cnt_q;
  assign accept = iVALID && oREADY;

  always_ff @(posedge iCLK or negedge iRESET) begin
    if (!iRESET) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      oWE      <= '0;
      oADDR_WR <= '0;
      oDATA_WR <= '0;
      oSTART   <= 1'b0;
      oDROP    <= 1'b0;
    end else begin
      oWE    <= '0;
      oSTART <= 1'b0;
      if (iCLR) begin
        // A write registered last cycle is already on the bank ports and completes.
        state_q <= StIdle;
        cnt_q   <= '0;
        oDROP   <= 1'b0;
      end else begin
        if (iVALID && !oREADY) oDROP <= 1'b1;
        unique case (state_q)
          StIdle: state_q <= StLoad;
          StLoad: begin
            if (accept) begin
              oWE      <= 4'b0001 << rev[1:0];
              oADDR_WR <= rev[CW-1:2];
              oDATA_WR <= iDATA;
              if (cnt_q == LastIdx) begin
                cnt_q   <= '0;
                state_q <= StFlush;
              end else begin
                cnt_q <= cnt_q + 1'b1;
              end
            end
          end
          StFlush: begin
            // Last write is on the bank ports now; start lands the cycle after.
            oSTART  <= 1'b1;
            state_q <= StStart;
          end
          StStart: state_q <= StWaitBusy;
          StWaitBusy: begin
            if (!iFHT_RDY) state_q <= StWaitDone;
          end
          StWaitDone: begin
            if (iFHT_RDY) begin
              state_q <= StLoad;
              cnt_q   <= '0;
            end
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_fht_input_loader.sv
// Randomized self-checking bench for fht_input_loader (A_BIT = 2, N = 16).
`timescale 1ns / 100ps
module tb_fht_input_loader;

  localparam int unsigned A_BIT = 2;
  localparam int unsigned D_BIT = 16;
  localparam int NPTS = 16;

  localparam int P_IDLE = 0;
  localparam int P_LOAD = 1;
  localparam int P_FLUSH = 2;
  localparam int P_START = 3;
  localparam int P_WBUSY = 4;
  localparam int P_WDONE = 5;

  logic             iCLK;
  logic             iRESET;
  logic             iCLR;
  logic [D_BIT-1:0] iDATA;
  logic             iVALID;
  logic             oREADY;
  logic [A_BIT-1:0] oADDR_WR;
  logic [D_BIT-1:0] oDATA_WR;
  logic [3:0]       oWE;
  logic             oSTART;
  logic             iFHT_RDY;
  logic             oBUSY;
  logic             oDROP;
  logic [A_BIT+1:0] oCNT;

  fht_input_loader #(
    .A_BIT (A_BIT),
    .D_BIT (D_BIT)
  ) dut (
    .iCLK     (iCLK),
    .iRESET   (iRESET),
    .iCLR     (iCLR),
    .iDATA    (iDATA),
    .iVALID   (iVALID),
    .oREADY   (oREADY),
    .oADDR_WR (oADDR_WR),
    .oDATA_WR (oDATA_WR),
    .oWE      (oWE),
    .oSTART   (oSTART),
    .iFHT_RDY (iFHT_RDY),
    .oBUSY    (oBUSY),
    .oDROP    (oDROP),
    .oCNT     (oCNT)
  );

  initial begin
    iCLK = 1'b0;
    forever #5 iCLK = ~iCLK;
  end

  int n_vec = 0;
  int n_err = 0;

  // Reference model state: what the outputs must show at the next sample point.
  int          m_phase;
  int          m_cnt;
  bit          m_drop;
  logic [3:0]  m_we;
  int          m_addr;
  int          m_data;
  bit          m_start;
  int          bank_cnt[4];
  int          n_start;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int rev_idx(input int n);
    int r = 0;
    for (int i = 0; i < 4; i++) r = r * 2 + ((n >> i) & 1);
    return r;
  endfunction

  task automatic model_reset();
    m_phase = P_IDLE;
    m_cnt   = 0;
    m_drop  = 0;
    m_we    = 4'b0;
    m_addr  = 0;
    m_data  = 0;
    m_start = 0;
  endtask

  task automatic model_update(input bit v, input int d, input bit rdy, input bit clr);
    int r;
    if (clr) begin
      m_phase = P_IDLE;
      m_cnt   = 0;
      m_drop  = 0;
      m_we    = 4'b0;
      m_start = 0;
      return;
    end
    if (v && m_phase != P_LOAD) m_drop = 1;
    m_we    = 4'b0;
    m_start = 0;
    case (m_phase)
      P_IDLE: m_phase = P_LOAD;
      P_LOAD: begin
        if (v) begin
          r      = rev_idx(m_cnt);
          m_we   = 4'(1 << (r % 4));
          m_addr = r / 4;
          m_data = d & 16'hffff;
          if (m_cnt == NPTS - 1) begin
            m_cnt   = 0;
            m_phase = P_FLUSH;
          end else begin
            m_cnt++;
          end
        end
      end
      P_FLUSH: begin
        m_start = 1;
        m_phase = P_START;
      end
      P_START: m_phase = P_WBUSY;
      P_WBUSY: if (!rdy) m_phase = P_WDONE;
      P_WDONE: if (rdy) m_phase = P_LOAD;
      default: m_phase = P_IDLE;
    endcase
  endtask

  task automatic check_outputs();
    check("ready", 32'(oREADY), 32'(m_phase == P_LOAD));
    check("busy", 32'(oBUSY), 32'(m_phase == P_WBUSY || m_phase == P_WDONE));
    check("cnt", 32'(oCNT), 32'(m_cnt));
    check("drop", 32'(oDROP), 32'(m_drop));
    check("start", 32'(oSTART), 32'(m_start));
    check("we", 32'(oWE), 32'(m_we));
    if (m_we != 4'b0) begin
      check("addr", 32'(oADDR_WR), 32'(m_addr));
      check("data", 32'(oDATA_WR), 32'(m_data));
    end
    for (int b = 0; b < 4; b++) if (oWE[b]) bank_cnt[b]++;
    if (oSTART) n_start++;
  endtask

  // Called at a falling edge: drive, check, advance model, move to next falling edge.
  task automatic step(input bit v, input int d, input bit rdy, input bit clr);
    iVALID   = v;
    iDATA    = D_BIT'(d);
    iFHT_RDY = rdy;
    iCLR     = clr;
    check_outputs();
    model_update(v, d, rdy, clr);
    @(negedge iCLK);
  endtask

  task automatic feed(input int accepts, input bit gaps, input bit seq);
    int got = 0;
    bit v;
    int d;
    for (int c = 0; c < 400 && got < accepts; c++) begin
      v = (m_phase == P_LOAD) && (!gaps || ($urandom_range(0, 1) == 1));
      d = seq ? m_cnt : int'($urandom_range(0, 16'hffff));
      step(v, d, 1'b1, 1'b0);
      if (v) got++;
    end
    check("feed_accepts", 32'(got), 32'(accepts));
  endtask

  task automatic frame(input bit gaps, input bit seq);
    int s0;
    for (int b = 0; b < 4; b++) bank_cnt[b] = 0;
    s0 = n_start;
    feed(NPTS, gaps, seq);
    step(1'b0, 0, 1'b1, 1'b0);
    step(1'b0, 0, 1'b1, 1'b0);
    for (int b = 0; b < 4; b++) check("bank_writes", 32'(bank_cnt[b]), 32'd4);
    check("start_pulses", 32'(n_start - s0), 32'd1);
  endtask

  task automatic handoff(input bit ovf);
    for (int i = 0; i < 3; i++) step(1'b0, 0, 1'b1, 1'b0);
    for (int i = 0; i < 50; i++)
      step(ovf && (i % 7 == 3), int'($urandom_range(0, 16'hffff)), 1'b0, 1'b0);
    step(1'b0, 0, 1'b1, 1'b0);
    step(1'b0, 0, 1'b1, 1'b0);
  endtask

  task automatic reset_mid();
    iVALID = 1'b0;
    iCLR   = 1'b0;
    check_outputs();
    #2 iRESET = 1'b0;
    #0.5;
    check("rst_ready", 32'(oREADY), 32'd0);
    check("rst_we", 32'(oWE), 32'd0);
    check("rst_start", 32'(oSTART), 32'd0);
    check("rst_busy", 32'(oBUSY), 32'd0);
    check("rst_drop", 32'(oDROP), 32'd0);
    check("rst_cnt", 32'(oCNT), 32'd0);
    check("rst_addr", 32'(oADDR_WR), 32'd0);
    check("rst_data", 32'(oDATA_WR), 32'd0);
    #0.5 iRESET = 1'b1;
    model_reset();
    model_update(1'b0, 0, 1'b1, 1'b0);
    @(negedge iCLK);
  endtask

  initial begin
    int s0;
    iRESET   = 1'b0;
    iCLR     = 1'b0;
    iVALID   = 1'b0;
    iDATA    = '0;
    iFHT_RDY = 1'b1;
    n_start  = 0;
    model_reset();
    @(negedge iCLK);
    check_outputs();
    check("init_addr", 32'(oADDR_WR), 32'd0);
    check("init_data", 32'(oDATA_WR), 32'd0);
    iRESET = 1'b1;
    model_update(1'b0, 0, 1'b1, 1'b0);
    @(negedge iCLK);

    // Gap-free frame of samples 0..15, then handoff.
    frame(1'b0, 1'b1);
    handoff(1'b0);

    // Random handshake gaps and random data.
    frame(1'b1, 1'b0);
    handoff(1'b0);

    // Overflow during the FHT wait, then clear it.
    frame(1'b1, 1'b0);
    handoff(1'b1);
    step(1'b0, 0, 1'b1, 1'b0);
    step(1'b0, 0, 1'b1, 1'b1);
    step(1'b0, 0, 1'b1, 1'b0);

    // Abort after 7 accepts, then a full frame.
    s0 = n_start;
    feed(7, 1'b1, 1'b0);
    step(1'b0, 0, 1'b1, 1'b1);
    step(1'b0, 0, 1'b1, 1'b0);
    check("abort_no_start", 32'(n_start - s0), 32'd0);
    frame(1'b0, 1'b0);
    handoff(1'b0);

    // Asynchronous reset mid-frame, then a full frame.
    s0 = n_start;
    feed(5, 1'b0, 1'b0);
    reset_mid();
    check("reset_no_start", 32'(n_start - s0), 32'd0);
    frame(1'b1, 1'b0);
    handoff(1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
